// File: rtl/spi_master_if.sv
// spi_master_if -- host-side handshake bundle for spi_master.
//   start   : one-cycle request to send dat_in
//   last    : sampled with start; 1 closes the burst after this byte
//   dat_in  : byte to transmit, sampled with start
//   dat_out : byte received in the most recent transfer
//   busy    : transfer or guard in progress (start ignored)
//   done    : one-cycle pulse, dat_out valid from this cycle
// Modports: master = host side, slave = spi_master side.
interface spi_master_if;
  logic       start;
  logic       last;
  logic [7:0] dat_in;
  logic [7:0] dat_out;
  logic       busy;
  logic       done;

  modport master (output start, last, dat_in, input dat_out, busy, done);
  modport slave  (input start, last, dat_in, output dat_out, busy, done);
endinterface

// File: rtl/spi_master.sv
// spi_master -- single-byte SPI mode 0 master with burst (held-select) support.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave modport) : start/last/dat_in in, dat_out/busy/done out
//   spi_sck/mosi/ss     : SPI outputs (ss active low), spi_miso input
// Parameter CLK_DIV: clk cycles per SCK half-period (0 is treated as 1).
// Build option SPI_MST_LSB_FIRST_EN: when defined, bits go out and are
// assembled LSB first; otherwise MSB first. Timing is identical either way.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  bus,
  output logic         spi_sck,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_ss
);

  localparam int         DIV_I  = (CLK_DIV < 1) ? 1 : CLK_DIV;
  localparam logic [7:0] DIV_M1 = 8'(DIV_I - 1);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_LEAD, S_HIGH, S_DONE, S_GUARD} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;     // bits still to send after the current one
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] dat_q, dat_d;
  logic       last_q, last_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       ss_q, ss_d;
  logic       ph_end;
  logic       busy, done;

  assign ph_end = (cnt_q == DIV_M1);

  // State register plus datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HOLD: if (bus.start) state_d = S_LEAD;
      S_LEAD:         if (ph_end) state_d = S_HIGH;
      S_HIGH:         if (ph_end) state_d = (bit_q == 3'd0) ? S_DONE : S_LEAD;
      S_DONE:         state_d = last_q ? S_GUARD : S_HOLD;
      S_GUARD:        if (ph_end) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath: counter, shift registers and registered SPI pins
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    dat_d  = dat_q;
    last_d = last_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    ss_d   = ss_q;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (bus.start) begin
          tx_d   = bus.dat_in;
          last_d = bus.last;
          ss_d   = 1'b0;
          cnt_d  = '0;
          bit_d  = 3'd7;
          sck_d  = 1'b0;
`ifdef SPI_MST_LSB_FIRST_EN
          mosi_d = bus.dat_in[0];
`else
          mosi_d = bus.dat_in[7];
`endif
        end
      end
      S_LEAD: begin
        if (ph_end) begin
          cnt_d = '0;
          sck_d = 1'b1;
`ifdef SPI_MST_LSB_FIRST_EN
          rx_d  = {spi_miso, rx_q[7:1]};
`else
          rx_d  = {rx_q[6:0], spi_miso};
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (ph_end) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
`ifdef SPI_MST_LSB_FIRST_EN
            tx_d   = {1'b0, tx_q[7:1]};
            mosi_d = tx_q[1];
`else
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
`endif
          end else begin
            // Final falling edge: park mosi low and publish the byte so
            // dat_out is already valid in the done cycle.
            mosi_d = 1'b0;
            dat_d  = rx_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (last_q) ss_d = 1'b1;
      end
      S_GUARD: begin
        cnt_d = ph_end ? 8'd0 : cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_LEAD, S_HIGH, S_GUARD: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.dat_out = dat_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign spi_ss      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  localparam int D = 4;

  logic clk, rst;
  logic spi_sck, spi_mosi, spi_miso, spi_ss;
  spi_master_if bus();

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low
  int mode;
  always_comb begin
    case (mode)
      1:       spi_miso = ~spi_mosi;
      2:       spi_miso = 1'b1;
      3:       spi_miso = 1'b0;
      default: spi_miso = spi_mosi;
    endcase
  end

  // Line monitor: cumulative counters, sampled on the falling clk edge
  int       rise_cnt = 0, ss_hi = 0, done_cnt = 0;
  logic     sck_prev = 1'b0;
  logic [7:0] mon_sr = 8'h00;
  always @(negedge clk) begin
    if (spi_sck && !sck_prev) begin
      rise_cnt <= rise_cnt + 1;
`ifdef SPI_MST_LSB_FIRST_EN
      mon_sr <= {spi_mosi, mon_sr[7:1]};
`else
      mon_sr <= {mon_sr[6:0], spi_mosi};
`endif
    end
    sck_prev <= spi_sck;
    if (spi_ss)   ss_hi    <= ss_hi + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  int tests = 0, fails = 0;
  logic prev_last = 1'b1;
  logic [7:0] sb_q[$];    // expected dat_out
  logic [7:0] mosi_q[$];  // expected bit stream on mosi

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_byte(input logic [7:0] d, input logic l, input logic [7:0] exp, input int poke_at);
    int n, r0, s0;
    logic [7:0] e;
    n = 0;
    while (bus.busy && n < 500) begin @(negedge clk); n++; end
    chk("idle_before_start", bus.busy, 0);
    if (!prev_last) chk("ss_held_in_burst", spi_ss, 0);
    sb_q.push_back(exp);
    mosi_q.push_back(d);
    bus.start = 1'b1; bus.dat_in = d; bus.last = l;
    @(negedge clk);
    bus.start = 1'b0;
    r0 = rise_cnt; s0 = ss_hi;
    n = 1;
    while (!bus.done && n < 400) begin
      bus.start = (n == poke_at);
      if (n == poke_at) begin bus.dat_in = ~d; bus.last = 1'b0; end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("done_latency", n, 16 * D + 1);
    chk("sck_pulses", rise_cnt - r0, 8);
    chk("ss_low_during_byte", ss_hi - s0, 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("dat_out", bus.dat_out, e);
      e = mosi_q.pop_front();
      chk("mosi_bits", mon_sr, e);
    end
    if (l) begin
      @(negedge clk);
      chk("guard_ss", spi_ss, 1);
      chk("guard_sck", spi_sck, 0);
      n = 1;
      while (bus.busy && n < 100) begin @(negedge clk); n++; end
      chk("guard_len", n, D + 1);
      chk("dat_out_hold", bus.dat_out, exp);
    end
    prev_last = l;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       last;
    int         mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, d0;
    vecs[0] = '{8'hA5, 1'b1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h3C};
    vecs[2] = '{8'hC3, 1'b1, 0, 8'hC3};
    vecs[3] = '{8'h00, 1'b1, 2, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 8'hA5};
    vecs[5] = '{8'hFF, 1'b1, 3, 8'h00};
    vecs[6] = '{8'h01, 1'b1, 0, 8'h01};
    vecs[7] = '{8'h96, 1'b0, 1, 8'h69};
    vecs[8] = '{8'hE7, 1'b1, 0, 8'hE7};

    mode = 0;
    rst = 1'b1; bus.start = 1'b0; bus.last = 1'b0; bus.dat_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ss", spi_ss, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dat_out", bus.dat_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      do_byte(vecs[i].dat, vecs[i].last, vecs[i].exp, 0);
    end

    // start pulsed while busy must be dropped
    mode = 0;
    d0 = done_cnt;
    do_byte(8'h81, 1'b1, 8'h81, 10);
    repeat (50) @(negedge clk);
    chk("single_done_after_poke", done_cnt - d0, 1);
    chk("idle_after_poke", bus.busy, 0);

    // reset in the middle of a byte
    d0 = done_cnt;
    bus.start = 1'b1; bus.dat_in = 8'h5A; bus.last = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 30) begin @(negedge clk); n++; end
    chk("mid_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ss", spi_ss, 1);
    chk("midrst_sck", spi_sck, 0);
    chk("midrst_mosi", spi_mosi, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_dat_out", bus.dat_out, 8'h00);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("idle_after_rst", bus.busy, 0);
    prev_last = 1'b1;

    // transfer still works after a mid-byte reset
    do_byte(8'h5A, 1'b1, 8'h5A, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
